matrix_read_engine: RTL
=======================

Name: matrix_read_engine

Overview:
- AXI4 burst-read responder to the accelerator controller's transaction-start pulse.
- On init_txn, latches the matrix A and B base addresses and dimensions, then fetches both N×N operand matrices of 32-bit words over the AXI4 read channels.
- Streams each returned word into the local operand buffers through a simple write port, then pulses read_done back to the controller.
- Sits between the controller and the AXI interconnect, upstream of the systolic array buffers.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32 (one element per beat).
- C_M_AXI_BURST_LEN, 16, maximum beats per burst (power of two, 1..16).
- BUF_ADDR_WIDTH, 8, buffer index width; must hold 15*15-1 = 224.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESET  in  1  synchronous reset, active-high
- init_txn  in  1  start pulse from controller
- MatrixAAddress  in  32  byte base of A; 64-byte aligned
- MatrixADimensions  in  4  N for A (N×N words)
- MatrixBAddress  in  32  byte base of B; 64-byte aligned
- MatrixBDimensions  in  4  N for B
- busy  out  1  high from accepted init until read_done
- read_done  out  1  one-cycle completion pulse
- read_error  out  1  sticky error flag; cleared on next accepted init
- buf_wr_en  out  1  buffer write strobe
- buf_sel  out  1  0 = A buffer, 1 = B buffer
- buf_wr_addr  out  BUF_ADDR_WIDTH  element index (row-major)
- buf_wr_data  out  32  element
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  burst address
- M_AXI_ARLEN  out  8  beats-1
- M_AXI_ARSIZE  out  3  constant 3'b010
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR)
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RLAST  in  1
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset (M_AXI_ARESET high at a clock edge):
  - State goes to IDLE.
  - All outputs 0 except the ARSIZE/ARBURST constants.
  - All counters 0.
  - Reset mid-operation abandons any outstanding burst; the interconnect/memory is reset with the engine.
- States: IDLE, ADDR, DATA, NEXT, DONE.
- IDLE:
  - init_txn=1 latches all four address/dimension inputs and clears read_error.
  - Sets busy=1, selects matrix A (buf_sel=0), word index = 0, remaining = N_A*N_A; goes to ADDR.
  - If remaining = 0 (dimension 0), A is skipped and B is selected the same cycle; if both are 0, go straight to DONE.
- init_txn while busy is ignored; the latched values do not change.
- ADDR:
  - M_AXI_ARVALID=1 is registered, so it asserts the cycle after init.
  - ARADDR = base + 4*word_index.
  - ARLEN = min(remaining, C_M_AXI_BURST_LEN) - 1.
  - All AR outputs are held stable until ARREADY.
  - On ARVALID&ARREADY: drop ARVALID next cycle, load beat counter = ARLEN+1, go to DATA.
  - One burst outstanding at a time.
  - 64-byte alignment guarantees no burst crosses a 4 KB boundary.
- DATA:
  - RREADY=1.
  - Each RVALID&RREADY beat, registered one cycle later:
    - buf_wr_en=1, buf_wr_addr = word index, buf_wr_data = RDATA.
    - word index +1, remaining -1, beat counter -1.
  - RRESP != 2'b00 on any beat sets read_error (sticky); the data is still written and the transfer continues.
  - The burst ends on the beat where the beat counter reaches 1, or on RLAST, whichever comes first. If the two disagree, read_error is set.
  - Leaving DATA drops RREADY in the next cycle.
- NEXT:
  - If remaining > 0: go to ADDR.
  - Else if buf_sel=0 and N_B > 0: buf_sel=1, word index = 0, remaining = N_B*N_B, go to ADDR.
  - Else: go to DONE.
- DONE: read_done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- Latency:
  - init to first ARVALID: 1 cycle.
  - Last R handshake to read_done: 3 cycles (DATA exit, NEXT, DONE).
- Arithmetic:
  - N*N uses an 8-bit product; max 225.
  - Word index wraps to 0 when switching matrices; it never wraps within a matrix.
  - Address add is modulo 2^C_M_AXI_ADDR_WIDTH.

Test Plan:
- A=0x1000 N=2, B=0x2000 N=3 → AR (0x1000, LEN 3), 4 A writes idx 0..3; then AR (0x2000, LEN 8), 9 B writes idx 0..8; read_done single pulse; read_error=0.
- A N=5 → bursts (0x1000, LEN 15) then (0x1040, LEN 8); A idx 0..24 written in order with matching data.
- ARREADY held low 7 cycles → ARVALID/ARADDR/ARLEN stable for all 8 cycles; single handshake.
- RVALID toggled randomly; RRESP=SLVERR on beat 2 → all beats written, read_error=1 after done, cleared by the next init.
- init pulsed mid-transfer → ignored, addresses unchanged; A N=0, B N=0 → no AR; read_done 2 cycles after init.
- Reset asserted during DATA → next cycle all outputs 0 and state IDLE; a fresh init completes normally.

Source files
------------

// File: rtl/matrix_read_engine.sv
// matrix_read_engine: on a controller start pulse, fetches the N x N word matrices A and B over
// AXI4 INCR read bursts and streams every returned word into the local operand buffers.
module matrix_read_engine #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_BURST_LEN  = 16,
  parameter int unsigned BUF_ADDR_WIDTH     = 8
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          init_txn,
  input  logic [31:0]                   MatrixAAddress,
  input  logic [3:0]                    MatrixADimensions,
  input  logic [31:0]                   MatrixBAddress,
  input  logic [3:0]                    MatrixBDimensions,
  output logic                          busy,
  output logic                          read_done,
  output logic                          read_error,
  output logic                          buf_wr_en,
  output logic                          buf_sel,
  output logic [BUF_ADDR_WIDTH-1:0]     buf_wr_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] buf_wr_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam logic [7:0] BurstLen = 8'(C_M_AXI_BURST_LEN);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StNext, StDone} state_e;

  state_e                          state_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   a_base_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   b_base_q;
  logic [3:0]                      b_dim_q;
  logic [BUF_ADDR_WIDTH-1:0]       word_idx_q;
  logic [7:0]                      remaining_q;
  logic [7:0]                      beat_cnt_q;

  logic [7:0]                      a_words_in;
  logic [7:0]                      b_words_in;
  logic [7:0]                      b_words_lat;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   next_addr;
  logic                            beat_last;
  logic                            burst_end;

  // ARLEN for a burst covering up to `words` remaining elements
  function automatic logic [7:0] burst_m1(input logic [7:0] words);
    return (words > BurstLen) ? BurstLen - 8'd1 : words - 8'd1;
  endfunction

  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;

  // Element counts (8-bit products, max 225) and the next burst address in the active matrix
  always_comb begin
    a_words_in  = 8'(MatrixADimensions) * 8'(MatrixADimensions);
    b_words_in  = 8'(MatrixBDimensions) * 8'(MatrixBDimensions);
    b_words_lat = 8'(b_dim_q) * 8'(b_dim_q);
    next_addr   = (buf_sel ? b_base_q : a_base_q)
                  + (C_M_AXI_ADDR_WIDTH'(word_idx_q) << 2);
    beat_last   = (beat_cnt_q == 8'd1);
    burst_end   = beat_last | M_AXI_RLAST;
  end

  // Main control FSM; all outputs registered
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q       <= StIdle;
      a_base_q      <= '0;
      b_base_q      <= '0;
      b_dim_q       <= '0;
      word_idx_q    <= '0;
      remaining_q   <= '0;
      beat_cnt_q    <= '0;
      busy          <= 1'b0;
      read_done     <= 1'b0;
      read_error    <= 1'b0;
      buf_wr_en     <= 1'b0;
      buf_sel       <= 1'b0;
      buf_wr_addr   <= '0;
      buf_wr_data   <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARLEN   <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      buf_wr_en <= 1'b0;
      read_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (init_txn) begin
            a_base_q   <= C_M_AXI_ADDR_WIDTH'(MatrixAAddress);
            b_base_q   <= C_M_AXI_ADDR_WIDTH'(MatrixBAddress);
            b_dim_q    <= MatrixBDimensions;
            read_error <= 1'b0;
            busy       <= 1'b1;
            word_idx_q <= '0;
            if (a_words_in != 8'd0) begin
              buf_sel       <= 1'b0;
              remaining_q   <= a_words_in;
              M_AXI_ARADDR  <= C_M_AXI_ADDR_WIDTH'(MatrixAAddress);
              M_AXI_ARLEN   <= burst_m1(a_words_in);
              M_AXI_ARVALID <= 1'b1;
              state_q       <= StAddr;
            end else if (b_words_in != 8'd0) begin
              // Empty A: go straight to B
              buf_sel       <= 1'b1;
              remaining_q   <= b_words_in;
              M_AXI_ARADDR  <= C_M_AXI_ADDR_WIDTH'(MatrixBAddress);
              M_AXI_ARLEN   <= burst_m1(b_words_in);
              M_AXI_ARVALID <= 1'b1;
              state_q       <= StAddr;
            end else begin
              buf_sel     <= 1'b0;
              remaining_q <= '0;
              state_q     <= StDone;
            end
          end
        end
        StAddr: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            beat_cnt_q    <= M_AXI_ARLEN + 8'd1;
            M_AXI_RREADY  <= 1'b1;
            state_q       <= StData;
          end
        end
        StData: begin
          if (M_AXI_RVALID && M_AXI_RREADY) begin
            buf_wr_en   <= 1'b1;
            buf_wr_addr <= word_idx_q;
            buf_wr_data <= M_AXI_RDATA;
            word_idx_q  <= word_idx_q + 1'b1;
            if (remaining_q != 8'd0) remaining_q <= remaining_q - 8'd1;
            if (beat_cnt_q != 8'd0) beat_cnt_q <= beat_cnt_q - 8'd1;
            // Error responses and RLAST/beat-count disagreement are flagged but not fatal
            if ((M_AXI_RRESP != 2'b00) || (beat_last != M_AXI_RLAST)) read_error <= 1'b1;
            if (burst_end) begin
              M_AXI_RREADY <= 1'b0;
              state_q      <= StNext;
            end
          end
        end
        StNext: begin
          if (remaining_q != 8'd0) begin
            M_AXI_ARADDR  <= next_addr;
            M_AXI_ARLEN   <= burst_m1(remaining_q);
            M_AXI_ARVALID <= 1'b1;
            state_q       <= StAddr;
          end else if (!buf_sel && (b_dim_q != 4'd0)) begin
            buf_sel       <= 1'b1;
            word_idx_q    <= '0;
            remaining_q   <= b_words_lat;
            M_AXI_ARADDR  <= b_base_q;
            M_AXI_ARLEN   <= burst_m1(b_words_lat);
            M_AXI_ARVALID <= 1'b1;
            state_q       <= StAddr;
          end else begin
            state_q <= StDone;
          end
        end
        StDone: begin
          read_done <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
